// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order imem reads and queues returned words
// (with their PC) for decode. A redirect flushes the queue and drops responses still in flight.
//
// state | meaning
// BOOT  | single idle cycle after reset; no requests, redirects ignored
// RUN   | fetching; a request is made while in-flight + buffered words < DEPTH
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        PCSrc,
   input  logic [31:0] branch_target
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   typedef enum logic {
      BOOT,
      RUN
   } state_t;

   state_t           state;
   logic [31:0]      fetch_pc;
   logic [31:0]      resp_pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_nxt;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   occupancy;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [31:0]      buf_instr [DEPTH];
   logic [31:0]      buf_pc    [DEPTH];

   logic        redirect;
   logic        issue;
   logic        resp;
   logic        push;
   logic        pop;
   logic [31:0] target_pc;
   logic        unused_target_bits;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign target_pc          = {branch_target[31:2], 2'b00};
   assign unused_target_bits = ^branch_target[1:0];

   assign occupancy = {1'b0, outstanding} + {1'b0, count};
   assign imem_req  = (state == RUN) & ~PCSrc & (occupancy < {1'b0, DEPTH_C});
   assign imem_addr = fetch_pc;

   assign redirect = (state == RUN) & PCSrc;
   assign issue    = imem_req & imem_gnt;
   // A response with nothing in flight is a protocol error; keep the counters sane by ignoring it.
   assign resp     = imem_rvalid & (outstanding != '0);
   assign push     = resp & (drop_cnt == '0) & ~redirect;
   assign pop      = instr_valid & instr_ready;

   assign outstanding_nxt = outstanding + CNT_W'(issue) - CNT_W'(resp);

   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? buf_instr[rd_ptr] : 32'h0;
   assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         case (state)
            BOOT:    state <= RUN;
            RUN:     state <= RUN;
            default: state <= BOOT;
         endcase

         outstanding <= outstanding_nxt;

         if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc <= target_pc;
            resp_pc  <= target_pc;
            drop_cnt <= outstanding_nxt;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (issue) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (resp) begin
               if (drop_cnt != '0) begin
                  drop_cnt <= drop_cnt - CNT_W'(1);
               end else begin
                  resp_pc <= resp_pc + 32'd4;
               end
            end
            if (push) begin
               wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
               rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr[wr_ptr] <= imem_rdata;
         buf_pc[wr_ptr]    <= resp_pc;
      end
   end

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> ((count != DEPTH_C) || pop));

   a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rvalid |-> (outstanding != '0));

   a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
      outstanding <= DEPTH_C);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model with random grant/latency, a PC-stream
// scoreboard for decode, redirect vector table and hand-written reset/flush sequences.
module tb_instr_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        PCSrc;
   logic [31:0] branch_target;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .PCSrc(PCSrc), .branch_target(branch_target)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic [31:0] target;
      logic [31:0] first_addr;
      logic [31:0] second_addr;
   } redir_vec_t;

   pend_t      pend[$];
   redir_vec_t vecs[5];

   int          n_checks, n_fail;
   int          cyc, buffered, stale, issues;
   logic [31:0] exp_pc, exp_fetch;
   bit          running;
   int          gnt_pct, ready_pct, lat_lo, lat_hi;
   bit          rand_pcsrc, force_pcsrc;
   logic [31:0] force_target;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   task automatic model_reset();
      pend.delete();
      buffered  = 0;
      stale     = 0;
      exp_pc    = RESET_PC;
      exp_fetch = RESET_PC;
      running   = 1'b0;
   endtask

   // One clock: drive inputs just after the edge, check and update the model, then advance.
   task automatic cycle();
      bit          rv, iss, cons, redir;
      logic [31:0] t;
      rv = (pend.size() > 0) && (pend[0].due <= cyc);
      imem_rvalid = rv;
      if (rv) imem_rdata = mem_word(pend[0].addr);
      else    imem_rdata = $urandom;
      imem_gnt      = ($urandom_range(99) < gnt_pct);
      instr_ready   = ($urandom_range(99) < ready_pct);
      PCSrc         = force_pcsrc || (rand_pcsrc && ($urandom_range(99) < 4));
      branch_target = force_pcsrc ? force_target : $urandom;
      #1;
      chk("imem_addr", imem_addr, exp_fetch);
      chk("instr_valid", instr_valid, buffered > 0);
      if (buffered == 0) chk("instr_when_empty", instr, 32'h0);
      if (running) chk("imem_req", imem_req, !PCSrc && ((pend.size() + buffered) < DEPTH));
      else         chk("imem_req_boot", imem_req, 1'b0);

      iss   = imem_req && imem_gnt;
      redir = running && PCSrc;
      cons  = instr_valid && instr_ready;
      if (cons && !redir) begin
         chk("instr_pc", instr_pc, exp_pc);
         chk("instr", instr, mem_word(exp_pc));
         exp_pc += 32'd4;
         if (buffered > 0) buffered--;
      end
      if (rv) begin
         void'(pend.pop_front());
         if (stale > 0)   stale--;
         else if (!redir) buffered++;
      end
      if (iss) begin
         pend.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
         exp_fetch += 32'd4;
         issues++;
      end
      if (redir) begin
         t         = {branch_target[31:2], 2'b00};
         exp_fetch = t;
         exp_pc    = t;
         buffered  = 0;
         stale     = pend.size();
      end
      running = (rst_n === 1'b1);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_inflight(input int n, input string name);
      int w;
      w = 0;
      while (pend.size() < n && w < 20) begin
         cycle();
         w++;
      end
      if (pend.size() < n) timeout_fail(name);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int iss0;
      vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
      vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[3] = '{32'h0000_2002, 32'h0000_2000, 32'h0000_2004};
      vecs[4] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};

      n_checks = 0; n_fail = 0; cyc = 0; issues = 0;
      gnt_pct = 100; ready_pct = 100; lat_lo = 1; lat_hi = 1;
      rand_pcsrc = 1'b0; force_pcsrc = 1'b0; force_target = '0;
      rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0; PCSrc = 1'b0; branch_target = '0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      rst_n = 1'b1;

      // Streaming from reset; a redirect during BOOT must be ignored.
      force_pcsrc  = 1'b1;
      force_target = 32'h0000_0500;
      cycle();
      force_pcsrc = 1'b0;
      repeat (20) cycle();

      // Backpressure: buffer fills to DEPTH, requests stop, nothing lost on release.
      ready_pct = 0;
      repeat (8) cycle();
      chk("bp_req_stalled", imem_req, 1'b0);
      chk("bp_head_pc", instr_pc, exp_pc);
      ready_pct = 100;
      repeat (10) cycle();

      // Redirect table with two requests in flight (3-cycle memory).
      lat_lo = 3; lat_hi = 3;
      foreach (vecs[i]) begin
         wait_inflight(2, "inflight_before_redirect");
         force_pcsrc  = 1'b1;
         force_target = vecs[i].target;
         cycle();
         force_pcsrc = 1'b0;
         chk("redir_first_addr", imem_addr, vecs[i].first_addr);
         iss0 = issues;
         w    = 0;
         while (issues == iss0 && w < 20) begin
            cycle();
            w++;
         end
         if (issues == iss0) timeout_fail("redir_issue");
         chk("redir_second_addr", imem_addr, vecs[i].second_addr);
         repeat (10) cycle();
      end

      // Redirect coinciding with a response and a decode consume.
      lat_lo = 1; lat_hi = 1; ready_pct = 0;
      force_pcsrc  = 1'b1;
      force_target = 32'h0000_4000;
      cycle();
      force_pcsrc = 1'b0;
      w = 0;
      while (!(buffered > 0 && pend.size() > 0 && pend[0].due <= cyc) && w < 20) begin
         cycle();
         w++;
      end
      if (w >= 20) timeout_fail("flush_setup");
      ready_pct    = 100;
      force_pcsrc  = 1'b1;
      force_target = 32'h0000_6000;
      cycle();
      force_pcsrc = 1'b0;
      chk("flush_instr_valid", instr_valid, 1'b0);
      chk("flush_addr", imem_addr, 32'h0000_6000);
      repeat (8) cycle();

      // Reset mid-stream with two requests outstanding; a late response during reset is ignored.
      lat_lo = 3; lat_hi = 3;
      wait_inflight(2, "inflight_before_reset");
      rst_n = 1'b0;
      #1;
      chk("midrst_imem_req", imem_req, 1'b0);
      chk("midrst_imem_addr", imem_addr, RESET_PC);
      chk("midrst_instr_valid", instr_valid, 1'b0);
      chk("midrst_instr", instr, 32'h0);
      chk("midrst_instr_pc", instr_pc, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      cyc++;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      cyc++;
      imem_rvalid = 1'b0;
      chk("late_rvalid_valid", instr_valid, 1'b0);
      rst_n = 1'b1;
      lat_lo = 1; lat_hi = 1;
      repeat (12) cycle();

      // Randomized traffic against the scoreboard.
      gnt_pct = 70; ready_pct = 60; lat_lo = 1; lat_hi = 3; rand_pcsrc = 1'b1;
      repeat (3000) cycle();
      rand_pcsrc = 1'b0;
      repeat (10) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
